// File: rtl/seq_decoder_if.sv
// -----------------------------------------------------------------------------
// seq_decoder_if
// Bundle of control inputs and decoded outputs for seq_decoder.
//   en     : enable; low blanks D and freezes sequencing
//   mode   : 00 direct, 01 scan-up, 10 scan-down, 11 one-shot sweep
//   sel    : index used in direct mode
//   dwell  : step length minus one for scan/sweep
//   start  : sweep trigger (mode 11 only)
//   D      : registered one-hot output, zero when blanked
//   idx    : registered current index
//   busy   : high while a one-shot sweep runs
//   wrap   : one-cycle pulse on scan wrap or sweep completion
// master drives the controls, slave is the decoder.
// -----------------------------------------------------------------------------
interface seq_decoder_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
);
    localparam int N = 1 << SEL_W;

    logic               en;
    logic [1:0]         mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic               start;
    logic [N-1:0]       D;
    logic [SEL_W-1:0]   idx;
    logic               busy;
    logic               wrap;

    modport master (
        output en, mode, sel, dwell, start,
        input  D, idx, busy, wrap
    );

    modport slave (
        input  en, mode, sel, dwell, start,
        output D, idx, busy, wrap
    );
endinterface

// File: rtl/seq_decoder.sv
// -----------------------------------------------------------------------------
// seq_decoder
// Registered one-hot decoder with direct addressing, up/down scanning with a
// programmable dwell, and a triggered single sweep.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_decoder_if.slave (en/mode/sel/dwell/start in, D/idx/busy/wrap out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module seq_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_decoder_if.slave  bus
);
    localparam int N = 1 << SEL_W;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_SWEEP  = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    logic [N-1:0]       d_q,     d_d;
    logic [SEL_W-1:0]   idx_q,   idx_d;
    logic               busy_q,  busy_d;
    logic               wrap_q,  wrap_d;
    logic [DWELL_W-1:0] cnt_q,   cnt_d;
    logic [1:0]         mode_q,  mode_d;
    logic [0:0]         state_q, state_d;
    logic               step_s;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Next-state logic for index, output pattern, dwell counter and sweep FSM
    always_comb begin
        mode_d  = mode_q;
        state_d = state_q;
        idx_d   = idx_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        // Live dwell compare: a reduced dwell takes effect on the very next edge.
        step_s  = (cnt_q >= bus.dwell);

        if (!bus.en) begin
            d_d     = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (bus.mode != mode_q) begin
            // First cycle of a new mode: settle, never advance.
            mode_d  = bus.mode;
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            case (bus.mode)
                MODE_DIRECT: begin
                    idx_d = bus.sel;
                    d_d   = onehot(bus.sel);
                end
                MODE_UP, MODE_DOWN: begin
                    d_d = onehot(idx_q);
                end
                MODE_SWEEP: begin
                    d_d = '0;
                end
                default: begin
                    d_d = '0;
                end
            endcase
        end else begin
            case (mode_q)
                MODE_DIRECT: begin
                    idx_d   = bus.sel;
                    d_d     = onehot(bus.sel);
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                MODE_UP: begin
                    busy_d = 1'b0;
                    if (step_s) begin
                        cnt_d  = '0;
                        idx_d  = idx_q + SEL_W'(1);
                        wrap_d = (idx_q == IDX_MAX);
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                    d_d = onehot(idx_d);
                end
                MODE_DOWN: begin
                    busy_d = 1'b0;
                    if (step_s) begin
                        cnt_d  = '0;
                        idx_d  = idx_q - SEL_W'(1);
                        wrap_d = (idx_q == SEL_W'(0));
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                    d_d = onehot(idx_d);
                end
                MODE_SWEEP: begin
                    case (state_q)
                        ST_IDLE: begin
                            d_d    = '0;
                            busy_d = 1'b0;
                            cnt_d  = '0;
                            if (bus.start) begin
                                idx_d   = SEL_W'(0);
                                d_d     = onehot(SEL_W'(0));
                                busy_d  = 1'b1;
                                state_d = ST_SWEEP;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        ST_SWEEP: begin
                            if (step_s) begin
                                cnt_d = '0;
                                if (idx_q == IDX_MAX) begin
                                    // Last step done: blank, finish, idx stays at top.
                                    d_d     = '0;
                                    busy_d  = 1'b0;
                                    wrap_d  = 1'b1;
                                    state_d = ST_IDLE;
                                end else begin
                                    idx_d = idx_q + SEL_W'(1);
                                    d_d   = onehot(idx_q + SEL_W'(1));
                                end
                            end else begin
                                cnt_d = cnt_q + DWELL_W'(1);
                            end
                        end
                        default: begin
                            d_d     = '0;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                default: begin
                    d_d     = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_DIRECT;
            state_q <= ST_IDLE;
        end else begin
            d_q     <= d_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            state_q <= state_d;
        end
    end

    assign bus.D    = d_q;
    assign bus.idx  = idx_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_seq_decoder.sv
// -----------------------------------------------------------------------------
// tb_seq_decoder
// Self-checking bench for seq_decoder (SEL_W=3, DWELL_W=4): a direct-mode
// vector table, hand-written multi-cycle sequences, and a randomized run, all
// compared against a behavioural model of the decoder's rules.
// -----------------------------------------------------------------------------
module tb_seq_decoder;
    localparam int SEL_W   = 3;
    localparam int DWELL_W = 4;
    localparam int N       = 1 << SEL_W;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    seq_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int m_idx;
    bit m_on;
    bit m_busy;
    bit m_wrap;
    int m_cnt;
    int m_mode;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [2:0] sel;
        logic [3:0] dwell;
        logic       start;
        logic [7:0] d;
        logic [2:0] idx;
        logic       busy;
        logic       wrap;
    } vec_t;

    vec_t vt[11];

    task automatic model_reset();
        m_idx = 0; m_on = 0; m_busy = 0; m_wrap = 0; m_cnt = 0; m_mode = 0;
    endtask

    task automatic model_step(input bit en, input int mode, input int sel,
                              input int dwell, input bit start);
        m_wrap = 0;
        if (!en) begin
            m_on = 0; m_busy = 0; m_cnt = 0;
        end else if (mode != m_mode) begin
            m_mode = mode; m_cnt = 0; m_busy = 0;
            if (mode == 0) begin m_idx = sel; m_on = 1; end
            else if (mode == 3) m_on = 0;
            else m_on = 1;
        end else if (mode == 0) begin
            m_idx = sel; m_on = 1; m_cnt = 0;
        end else if (mode == 1 || mode == 2) begin
            m_on = 1;
            if (m_cnt >= dwell) begin
                m_cnt = 0;
                if (mode == 1) begin
                    m_wrap = (m_idx == N - 1);
                    m_idx  = (m_idx + 1) % N;
                end else begin
                    m_wrap = (m_idx == 0);
                    m_idx  = (m_idx + N - 1) % N;
                end
            end else m_cnt++;
        end else begin
            if (!m_busy) begin
                m_on = 0; m_cnt = 0;
                if (start) begin m_idx = 0; m_on = 1; m_busy = 1; end
            end else if (m_cnt >= dwell) begin
                m_cnt = 0;
                if (m_idx == N - 1) begin m_on = 0; m_busy = 0; m_wrap = 1; end
                else m_idx++;
            end else m_cnt++;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] ed, input logic [2:0] ei,
                       input logic eb, input logic ew);
        checks++;
        if (bus.D !== ed || bus.idx !== ei || bus.busy !== eb || bus.wrap !== ew) begin
            failures++;
            $display("FAIL %s: got D=%h idx=%0d busy=%b wrap=%b, want D=%h idx=%0d busy=%b wrap=%b",
                     name, bus.D, bus.idx, bus.busy, bus.wrap, ed, ei, eb, ew);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic chk_model(input string name);
        logic [7:0] ed;
        ed = m_on ? (8'h01 << m_idx) : 8'h00;
        chk(name, ed, 3'(m_idx), m_busy, m_wrap);
    endtask

    // One clock: inputs already on the bus; advance model, compare 1 time unit after edge
    task automatic cyc(input string name);
        @(posedge clk);
        model_step(bus.en, int'(bus.mode), int'(bus.sel), int'(bus.dwell), bus.start);
        #1;
        chk_model(name);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic en, input logic [1:0] mode, input logic [2:0] sel,
                          input logic [3:0] dwell, input logic start);
        bus.en = en; bus.mode = mode; bus.sel = sel; bus.dwell = dwell; bus.start = start;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_busy;
        int n_wrap;
        bit done;
        bit found;
        logic [2:0] prev_idx;

        checks = 0;
        failures = 0;
        vt[0]  = '{1'b1, 2'b00, 3'd0, 4'd0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 2'b00, 3'd1, 4'd0, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 2'b00, 3'd2, 4'd0, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 2'b00, 3'd3, 4'd0, 1'b0, 8'h08, 3'd3, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 2'b00, 3'd4, 4'd0, 1'b0, 8'h10, 3'd4, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 2'b00, 3'd5, 4'd0, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 2'b00, 3'd6, 4'd0, 1'b0, 8'h40, 3'd6, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 2'b00, 3'd7, 4'd0, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 2'b00, 3'd3, 4'd0, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 2'b00, 3'd5, 4'd0, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0};
        vt[10] = '{1'b1, 2'b00, 3'd2, 4'd0, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0};

        set_in(1'b0, 2'b00, 3'd0, 4'd0, 1'b0);
        rst_n = 1'b0;
        #12;
        do_reset();
        @(posedge clk); #1;

        // Direct-mode table
        for (int i = 0; i < 11; i++) begin
            set_in(vt[i].en, vt[i].mode, vt[i].sel, vt[i].dwell, vt[i].start);
            cyc("direct_model");
            chk("direct_tbl", vt[i].d, vt[i].idx, vt[i].busy, vt[i].wrap);
        end

        // Scan-up, dwell=2: one wrap per 24 cycles, landing on D=01
        set_in(1'b1, 2'b01, 3'd0, 4'd2, 1'b0);
        cyc("scanup_enter");
        n_wrap = 0;
        for (int i = 0; i < 48; i++) begin
            cyc("scanup");
            if (bus.wrap) begin
                n_wrap++;
                chk("scanup_wrap_d", 8'h01, 3'd0, 1'b0, 1'b1);
            end
        end
        chk_int("scanup_wrap_count", n_wrap, 2);

        // Scan-down, dwell=0, from reset
        do_reset();
        set_in(1'b1, 2'b10, 3'd0, 4'd0, 1'b0);
        cyc("scandn_enter");
        chk("scandn_enter_d", 8'h01, 3'd0, 1'b0, 1'b0);
        cyc("scandn_first");
        chk("scandn_first_d", 8'h80, 3'd7, 1'b0, 1'b1);
        cyc("scandn_second");
        chk("scandn_second_d", 8'h40, 3'd6, 1'b0, 1'b0);

        // One-shot sweep, dwell=1, with a repeated start mid-sweep
        do_reset();
        set_in(1'b1, 2'b11, 3'd0, 4'd1, 1'b1);
        cyc("sweep_enter_start_ignored");
        chk("sweep_enter", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc("sweep_start");
        chk("sweep_start_d", 8'h01, 3'd0, 1'b1, 1'b0);
        bus.start = 1'b0;
        n_busy = 1;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            bus.start = (n_busy == 5);
            cyc("sweep_run");
            if (bus.busy) n_busy++;
            else done = 1'b1;
        end
        bus.start = 1'b0;
        chk_int("sweep_busy_cycles", n_busy, 16);
        chk("sweep_end", 8'h00, 3'd7, 1'b0, 1'b1);
        cyc("sweep_after");
        chk("sweep_after_d", 8'h00, 3'd7, 1'b0, 1'b0);

        // Mode switch 01 -> 10 while D=08
        set_in(1'b1, 2'b01, 3'd0, 4'd3, 1'b0);
        cyc("switch_enter_up");
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            cyc("switch_up");
            if (bus.D == 8'h08) found = 1'b1;
        end
        chk_int("switch_reach_08", int'(found), 1);
        bus.mode = 2'b10;
        cyc("switch_enter_dn");
        chk("switch_hold_08", 8'h08, 3'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc("switch_dwell");
        chk("switch_still_08", 8'h08, 3'd3, 1'b0, 1'b0);
        cyc("switch_advance");
        chk("switch_next_04", 8'h04, 3'd2, 1'b0, 1'b0);

        // Lower dwell 7 -> 1 while cnt=5: advance on next edge
        set_in(1'b1, 2'b01, 3'd0, 4'd7, 1'b0);
        cyc("dwell_enter");
        for (int k = 0; k < 5; k++) cyc("dwell_count");
        prev_idx = bus.idx;
        bus.dwell = 4'd1;
        cyc("dwell_cut");
        chk_int("dwell_cut_advance", int'(bus.idx), (int'(prev_idx) + 1) % N);

        // Async reset mid-sweep
        set_in(1'b1, 2'b11, 3'd0, 4'd3, 1'b0);
        cyc("arst_enter");
        bus.start = 1'b1;
        cyc("arst_start");
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) cyc("arst_run");
        chk_int("arst_busy_before", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_async", 8'h00, 3'd0, 1'b0, 1'b0);
        model_reset();
        #1;
        rst_n = 1'b1;
        #1;

        // Randomized run against the model
        set_in(1'b1, 2'b00, 3'd0, 4'd1, 1'b0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) bus.dwell = 4'($urandom_range(0, 4));
            bus.en    = ($urandom_range(0, 19) != 0);
            bus.sel   = 3'($urandom_range(0, 7));
            bus.start = ($urandom_range(0, 7) == 0);
            cyc("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
